// File: rtl/regfile_sequencer.sv
// Register-file initiator: fetches operands, runs a small ALU, retires results.
// Optional: define REGFILE_SEQ_SHIFT_EN to shift the B operand on load by IR[4:3].
module regfile_sequencer #(
  parameter int DW = 16,
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s,
  input  logic [15:0]   in,
  input  logic [DW-1:0] rf_rdata,
  output logic [RW-1:0] readnum,
  output logic [RW-1:0] writenum,
  output logic          write,
  output logic [DW-1:0] data_in,
  output logic          w,
  output logic          Z,
  output logic          N,
  output logic          V
);

  typedef enum logic [2:0] {
    WAIT, DECODE, GET_A, GET_B, EXEC, WRITE_REG, WRITE_IMM
  } state_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_CMP  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;

  state_t               state_q, state_d;
  logic [15:0]          ir_q, ir_d;
  logic signed [DW-1:0] a_q, a_d;
  logic signed [DW-1:0] b_q, b_d;
  logic signed [DW-1:0] c_q, c_d;
  logic                 z_q, z_d, n_q, n_d, v_q, v_d;
  logic [RW-1:0]        readnum_q, readnum_d;
  logic [RW-1:0]        writenum_q, writenum_d;
  logic [DW-1:0]        data_in_q, data_in_d;

  logic [2:0]           opcode, rn, rd, rm;
  logic [1:0]           op, sh;
  logic signed [DW-1:0] imm_sext;
  logic signed [DW-1:0] b_load;
  logic signed [DW-1:0] alu_res;
  logic                 is_mov;

  function automatic logic signed [DW-1:0] alu(input logic mov,
                                               input logic [1:0] f,
                                               input logic signed [DW-1:0] a,
                                               input logic signed [DW-1:0] b);
    if (mov) return b;
    case (f)
      OP_ADD:  return a + b;
      OP_CMP:  return a - b;
      OP_AND:  return a & b;
      default: return ~b;
    endcase
  endfunction

  function automatic logic sub_ovf(input logic signed [DW-1:0] a,
                                   input logic signed [DW-1:0] b,
                                   input logic signed [DW-1:0] d);
    return (a[DW-1] != b[DW-1]) && (d[DW-1] != a[DW-1]);
  endfunction

`ifdef REGFILE_SEQ_SHIFT_EN
  function automatic logic signed [DW-1:0] shift_b(input logic signed [DW-1:0] d,
                                                   input logic [1:0] mode);
    case (mode)
      2'b01:   return d <<< 1;
      2'b10:   return $signed($unsigned(d) >> 1);
      2'b11:   return d >>> 1;
      default: return d;
    endcase
  endfunction
`endif

  assign opcode   = ir_q[15:13];
  assign op       = ir_q[12:11];
  assign rn       = ir_q[10:8];
  assign rd       = ir_q[7:5];
  assign sh       = ir_q[4:3];
  assign rm       = ir_q[2:0];
  assign imm_sext = {{(DW-8){ir_q[7]}}, ir_q[7:0]};
  assign is_mov   = (opcode == OPC_MOV);

`ifdef REGFILE_SEQ_SHIFT_EN
  assign b_load = shift_b($signed(rf_rdata), sh);
`else
  assign b_load = $signed(rf_rdata);
`endif

  assign alu_res = alu(is_mov, op, a_q, b_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= WAIT;
      ir_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      z_q        <= 1'b0;
      n_q        <= 1'b0;
      v_q        <= 1'b0;
      readnum_q  <= '0;
      writenum_q <= '0;
      data_in_q  <= '0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      z_q        <= z_d;
      n_q        <= n_d;
      v_q        <= v_d;
      readnum_q  <= readnum_d;
      writenum_q <= writenum_d;
      data_in_q  <= data_in_d;
    end
  end

  // Select/data registers are loaded on entry to a state so they are stable throughout it.
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;
    z_d        = z_q;
    n_d        = n_q;
    v_d        = v_q;
    readnum_d  = readnum_q;
    writenum_d = writenum_q;
    data_in_d  = data_in_q;
    case (state_q)
      WAIT: begin
        if (s) begin
          ir_d    = in;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (opcode == OPC_MOV && op == 2'b10) begin
          writenum_d = RW'(rn);
          data_in_d  = $unsigned(imm_sext);
          state_d    = WRITE_IMM;
        end else if (opcode == OPC_MOV && op == 2'b00) begin
          readnum_d = RW'(rm);
          state_d   = GET_B;
        end else if (opcode == OPC_ALU) begin
          readnum_d = RW'(rn);
          state_d   = GET_A;
        end else begin
          state_d = WAIT;
        end
      end
      GET_A: begin
        a_d       = $signed(rf_rdata);
        readnum_d = RW'(rm);
        state_d   = GET_B;
      end
      GET_B: begin
        b_d = b_load;
        if (is_mov) a_d = '0;
        state_d = EXEC;
      end
      EXEC: begin
        c_d = alu_res;
        if (!is_mov && op == OP_CMP) begin
          z_d     = (alu_res == '0);
          n_d     = alu_res[DW-1];
          v_d     = sub_ovf(a_q, b_q, alu_res);
          state_d = WAIT;
        end else begin
          writenum_d = RW'(rd);
          data_in_d  = $unsigned(alu_res);
          state_d    = WRITE_REG;
        end
      end
      WRITE_REG: state_d = WAIT;
      WRITE_IMM: state_d = WAIT;
      default:   state_d = WAIT;
    endcase
  end

  // A write in flight is suppressed combinationally while reset is held.
  assign write    = ((state_q == WRITE_REG) || (state_q == WRITE_IMM)) && !reset;
  assign w        = (state_q == WAIT);
  assign readnum  = readnum_q;
  assign writenum = writenum_q;
  assign data_in  = data_in_q;
  assign Z        = z_q;
  assign N        = n_q;
  assign V        = v_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer with a behavioural 8x16 register file.
module tb_regfile_sequencer;
  logic        clk = 1'b0;
  logic        reset, s;
  logic [15:0] in;
  logic [15:0] rf_rdata;
  logic [2:0]  readnum, writenum;
  logic        write, w, Z, N, V;
  logic [15:0] data_in;

  logic [15:0] rf [8];
  logic        poke_en = 1'b0;
  logic [2:0]  poke_addr = '0;
  logic [15:0] poke_data = '0;

  int          checks = 0;
  int          errors = 0;
  logic [2:0]  rd_trace [12];
  logic [2:0]  wn_seen;
  logic [15:0] dv_seen;
  int          wr_cnt, wr_at, w_at;
  int          extra_wr;

  regfile_sequencer #(.DW(16), .RW(3)) dut (
    .clk(clk), .reset(reset), .s(s), .in(in), .rf_rdata(rf_rdata),
    .readnum(readnum), .writenum(writenum), .write(write), .data_in(data_in),
    .w(w), .Z(Z), .N(N), .V(V)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (write) rf[writenum] <= data_in;
    if (poke_en) rf[poke_addr] <= poke_data;
  end
  assign rf_rdata = rf[readnum];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  task automatic issue(input logic [15:0] instr);
    @(negedge clk);
    s = 1'b1; in = instr;
    @(posedge clk); #1;
    in = 16'hFFFF;
  endtask

  // k=0 is sampled just after the accepting edge; stops at the first cycle with w=1.
  task automatic exec(input logic [15:0] instr, input bit hold);
    issue(instr);
    if (!hold) s = 1'b0;
    wr_cnt = 0; wr_at = -1; w_at = -1;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      rd_trace[k] = readnum;
      if (write) begin
        wr_cnt++;
        if (wr_at < 0) begin wr_at = k; wn_seen = writenum; dv_seen = data_in; end
      end
      if (w) begin w_at = k; s = 1'b0; break; end
    end
  endtask

  initial begin
    reset = 1'b1; s = 1'b0; in = '0;
    for (int i = 0; i < 8; i++) rf[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_w", w, 1);
    check("rst_write", write, 0);
    check("rst_readnum", readnum, 0);
    check("rst_writenum", writenum, 0);
    check("rst_data_in", data_in, 0);
    check("rst_flags", {Z, N, V}, 0);
    @(negedge clk); reset = 1'b0;

    exec(16'hD107, 0);
    check("movi7_wr_at", wr_at, 1);
    check("movi7_wr_cnt", wr_cnt, 1);
    check("movi7_writenum", wn_seen, 1);
    check("movi7_data", dv_seen, 16'h0007);
    check("movi7_w_at", w_at, 2);

    exec(16'hD2FE, 0);
    check("movim2_writenum", wn_seen, 2);
    check("movim2_data", dv_seen, 16'hFFFE);

    exec(16'hA162, 0);
    check("add_readA", rd_trace[1], 1);
    check("add_readB", rd_trace[2], 2);
    check("add_wr_at", wr_at, 4);
    check("add_writenum", wn_seen, 3);
    check("add_data", dv_seen, 16'h0005);
    check("add_w_at", w_at, 5);

    exec(16'hB102, 0);
    check("and_writenum", wn_seen, 0);
    check("and_data", dv_seen, 16'h0006);

    exec(16'hB8E1, 0);
    check("mvn_writenum", wn_seen, 7);
    check("mvn_data", dv_seen, 16'hFFF8);
    check("mvn_w_at", w_at, 5);

    exec(16'hA162, 1);
    check("hold_wr_cnt", wr_cnt, 1);
    check("hold_w_at", w_at, 5);
    @(posedge clk); #1;
    check("hold_w_after", w, 1);
    check("hold_write_after", write, 0);

    // Reset while fetching B: the write must never appear.
    issue(16'hA162);
    s = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rstB_readnum", readnum, 2);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rstB_w", w, 1);
    check("rstB_write", write, 0);
    reset = 1'b0;
    extra_wr = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (write) extra_wr++;
    end
    check("rstB_no_write", extra_wr, 0);

    // Reset asserted inside the write cycle suppresses the strobe.
    poke(3'd6, 16'h1234);
    issue(16'hA1C2);
    s = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rstW_write_pre", write, 1);
    reset = 1'b1;
    #1;
    check("rstW_write_gated", write, 0);
    @(posedge clk); #1;
    check("rstW_w", w, 1);
    check("rstW_data_in", data_in, 0);
    check("rstW_rf6", rf[6], 16'h1234);
    reset = 1'b0;

    exec(16'hA901, 0);
    check("cmp11_wr_cnt", wr_cnt, 0);
    check("cmp11_w_at", w_at, 4);
    check("cmp11_flags", {Z, N, V}, 3'b100);

    exec(16'h0000, 0);
    check("ill_wr_cnt", wr_cnt, 0);
    check("ill_w_at", w_at, 1);
    check("ill_flags", {Z, N, V}, 3'b100);

    poke(3'd5, 16'h8000);
    poke(3'd6, 16'h0001);
    exec(16'hAD06, 0);
    check("cmpovf_wr_cnt", wr_cnt, 0);
    check("cmpovf_flags", {Z, N, V}, 3'b001);

    exec(16'hC089, 0);
    check("movr_writenum", wn_seen, 4);
    check("movr_w_at", w_at, 4);
`ifdef REGFILE_SEQ_SHIFT_EN
    check("movr_data", dv_seen, 16'h000E);
`else
    check("movr_data", dv_seen, 16'h0007);
`endif

    exec(16'hA121, 0);
    check("addsame_writenum", wn_seen, 1);
    check("addsame_data", dv_seen, 16'h000E);
    check("addsame_flags", {Z, N, V}, 3'b001);
    check("addsame_rf1", rf[1], 16'h000E);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
